// File: rtl/spi_frame_writer.sv
// spi_frame_writer: SPI mode-0 slave that assembles bytes in the master_clk
// domain and parses 5-byte character packets (FF, col, row, char, FE) into
// single-cycle frame-buffer writes, with an inter-byte timeout and an error
// counter.
module spi_frame_writer #(
  parameter int COLS      = 40,
  parameter int ROWS      = 15,
  parameter int ADDR_W    = 10,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 65535
) (
  input  logic              master_clk,
  input  logic              rst,
  input  logic              s_clk,
  input  logic              ss,
  input  logic              datain,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [7:0]        err_count,
  output logic [2:0]        state_dbg
);

  // Counter only needs to reach TIMEOUT-1; the hit is flagged on that value.
  localparam int              TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [8:0]      COLS_LIM = 9'(COLS);
  localparam logic [8:0]      ROWS_LIM = 9'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_COL  = 3'd1,
    S_ROW  = 3'd2,
    S_CHAR = 3'd3,
    S_END  = 3'd4
  } state_t;

  logic [2:0]        s_clk_sync_reg;
  logic [2:0]        ss_sync_reg;
  logic [1:0]        din_sync_reg;
  logic              sclk_rise;
  logic              ss_edge;
  logic              ss_active;

  logic [7:0]        shift_reg;
  logic [7:0]        shift_next;
  logic [2:0]        bit_cnt_reg;
  logic              byte_valid_reg;
  logic [7:0]        byte_data_reg;

  state_t            state_reg, state_next;
  logic [7:0]        col_reg, col_next;
  logic [7:0]        row_reg, row_next;
  logic [7:0]        char_reg, char_next;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              timeout_hit;
  logic              wr_fire;
  logic              err_fire;
  logic [ADDR_W-1:0] addr_calc;

  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              pkt_ok_reg;
  logic              pkt_err_reg;
  logic [7:0]        err_count_reg;

  // Bring the asynchronous SPI pins into the master_clk domain.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      s_clk_sync_reg <= '0;
      ss_sync_reg    <= '0;
      din_sync_reg   <= '0;
    end else begin
      s_clk_sync_reg <= {s_clk_sync_reg[1:0], s_clk};
      ss_sync_reg    <= {ss_sync_reg[1:0], ss};
      din_sync_reg   <= {din_sync_reg[0], datain};
    end
  end

  assign sclk_rise = s_clk_sync_reg[1] & ~s_clk_sync_reg[2];
  assign ss_edge   = ss_sync_reg[1] ^ ss_sync_reg[2];
  assign ss_active = ~ss_sync_reg[1];

  // Bit order is fixed at elaboration time.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = {shift_reg[6:0], din_sync_reg[1]};
    end else begin : g_lsb_first
      assign shift_next = {din_sync_reg[1], shift_reg[7:1]};
    end
  endgenerate

  // Byte assembly; any ss transition throws away a partial byte.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      byte_valid_reg <= 1'b0;
      byte_data_reg  <= '0;
    end else begin
      byte_valid_reg <= 1'b0;
      if (ss_edge) begin
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end else if (sclk_rise && ss_active) begin
        shift_reg <= shift_next;
        if (bit_cnt_reg == 3'd7) begin
          byte_data_reg  <= shift_next;
          byte_valid_reg <= 1'b1;
          bit_cnt_reg    <= '0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
      end
    end
  end

  // A byte arriving in the same cycle as the timeout takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (state_reg != S_IDLE) &&
                       (to_cnt_reg == TO_LAST);

  // Bounds were checked on entry, so truncation to ADDR_W is harmless.
  assign addr_calc = ADDR_W'(row_reg) * ADDR_W'(COLS) + ADDR_W'(col_reg);

  // Parser next-state logic; 0xFF in a field slot resynchronises to COL.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    char_next  = char_reg;
    wr_fire    = 1'b0;
    err_fire   = 1'b0;
    if (byte_valid_reg) begin
      case (state_reg)
        S_IDLE: begin
          if (byte_data_reg == 8'hFF) state_next = S_COL;
        end
        S_COL: begin
          if ({1'b0, byte_data_reg} < COLS_LIM) begin
            col_next   = byte_data_reg;
            state_next = S_ROW;
          end else begin
            err_fire   = 1'b1;
            state_next = (byte_data_reg == 8'hFF) ? S_COL : S_IDLE;
          end
        end
        S_ROW: begin
          if ({1'b0, byte_data_reg} < ROWS_LIM) begin
            row_next   = byte_data_reg;
            state_next = S_CHAR;
          end else begin
            err_fire   = 1'b1;
            state_next = (byte_data_reg == 8'hFF) ? S_COL : S_IDLE;
          end
        end
        S_CHAR: begin
          char_next  = byte_data_reg;
          state_next = S_END;
        end
        S_END: begin
          if (byte_data_reg == 8'hFE) begin
            wr_fire    = 1'b1;
            state_next = S_IDLE;
          end else begin
            err_fire   = 1'b1;
            state_next = (byte_data_reg == 8'hFF) ? S_COL : S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      err_fire   = 1'b1;
      state_next = S_IDLE;
    end
  end

  // Parser registers and the inter-byte timeout counter.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      col_reg    <= '0;
      row_reg    <= '0;
      char_reg   <= '0;
      to_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      char_reg  <= char_next;
      if (byte_valid_reg || state_reg == S_IDLE) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  // Registered write/status strobes and the saturating error counter.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      pkt_ok_reg    <= 1'b0;
      pkt_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      wr_en_reg   <= wr_fire;
      pkt_ok_reg  <= wr_fire;
      pkt_err_reg <= err_fire;
      if (wr_fire) begin
        wr_addr_reg <= addr_calc;
        wr_data_reg <= char_reg;
      end
      if (err_fire && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign byte_valid = byte_valid_reg;
  assign byte_data  = byte_data_reg;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign pkt_ok     = pkt_ok_reg;
  assign pkt_err    = pkt_err_reg;
  assign err_count  = err_count_reg;
  assign state_dbg  = state_reg;

endmodule
